// File: rtl/processor_reset_pkg.sv
// Shared types and constants for the processor reset requester.
package processor_reset_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ASSERT   = 3'd1,
      ST_WAIT_REL = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERROR    = 3'd4
   } state_e;

   localparam int CAUSE_SW  = 0;
   localparam int CAUSE_WDT = 1;
   localparam int CAUSE_DBG = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/processor_reset_requester.sv
// Turns sw/wdt/dbg reset requests into a stretched aux_reset pulse, then confirms the
// generator's bus_struct_reset asserted and released, reporting done, timeout and cause.
module processor_reset_requester
   import processor_reset_pkg::*;
#(
   parameter int PULSE_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       slowest_sync_clk,
   input  logic       sync_resetn,
   input  logic       sw_reset_req,
   input  logic       wdt_reset_req,
   input  logic       dbg_reset_req,
   input  logic       bus_struct_reset_in,
   input  logic       err_clr,
   output logic       aux_reset_out,
   output logic       busy,
   output logic       done,
   output logic       timeout_err,
   output logic [2:0] reset_cause
);

   localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ack_seen_q, ack_seen_d;
   logic             aux_q, aux_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [2:0]       cause_q, cause_d;
   logic [2:0]       req_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      req_s            = 3'b000;
      req_s[CAUSE_SW]  = sw_reset_req;
      req_s[CAUSE_WDT] = wdt_reset_req;
      req_s[CAUSE_DBG] = dbg_reset_req;
   end

   // Next-state, counter and registered-output logic of the request FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ack_seen_d = ack_seen_q;
      aux_d      = aux_q;
      done_d     = 1'b0;
      cause_d    = cause_q;
      // A clear in the cycle an ERROR is being reported must not win.
      if (err_clr && (state_q != ST_ERROR)) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (|req_s) begin
               state_d    = ST_ASSERT;
               cause_d    = req_s;
               aux_d      = 1'b1;
               ack_seen_d = 1'b0;
            end else begin
               aux_d = 1'b0;
            end
         end
         ST_ASSERT: begin
            ack_seen_d = ack_seen_q | bus_struct_reset_in;
            if (cnt_q == PULSE_LAST) begin
               aux_d = 1'b0;
               cnt_d = {CNT_W{1'b0}};
               if (ack_seen_q || bus_struct_reset_in) begin
                  state_d = ST_WAIT_REL;
               end else begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end
            end else begin
               aux_d = 1'b1;
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_WAIT_REL: begin
            if (!bus_struct_reset_in) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ERROR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            aux_d   = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge slowest_sync_clk) begin
      if (!sync_resetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         ack_seen_q <= 1'b0;
         aux_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cause_q    <= 3'b000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ack_seen_q <= ack_seen_d;
         aux_q      <= aux_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cause_q    <= cause_d;
      end
   end

   assign aux_reset_out = aux_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign timeout_err   = err_q;
   assign reset_cause   = cause_q;

endmodule

// File: tb/tb_processor_reset_requester.sv
// Directed bench with a generator model and a scoreboard of expected completions.
module tb_processor_reset_requester;

   logic       clk = 1'b0;
   logic       sync_resetn = 1'b0;
   logic       sw = 1'b0, wdt = 1'b0, dbg = 1'b0;
   logic       bus = 1'b0;
   logic       err_clr = 1'b0;
   logic       aux, busy, done, timeout_err;
   logic [2:0] cause;

   int total = 0;
   int bad   = 0;
   int gen_mode = 0;   // 0: echo aux one cycle late, 1: tied 0, 2: tied 1

   typedef struct {
      logic [2:0] cause;
      logic       is_err;
      int         pulse_len;
      int         lat;
   } exp_t;
   exp_t sb[$];

   int cyc = 0, run = 0, last_len = 0, fall_cyc = 0, pulses = 0;
   int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
   logic aux_prev = 1'b0, err_prev = 1'b0;

   processor_reset_requester #(.PULSE_CYCLES(16), .TIMEOUT_CYCLES(1024)) dut (
      .slowest_sync_clk    (clk),
      .sync_resetn         (sync_resetn),
      .sw_reset_req        (sw),
      .wdt_reset_req       (wdt),
      .dbg_reset_req       (dbg),
      .bus_struct_reset_in (bus),
      .err_clr             (err_clr),
      .aux_reset_out       (aux),
      .busy                (busy),
      .done                (done),
      .timeout_err         (timeout_err),
      .reset_cause         (cause)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      case (gen_mode)
         0:       bus <= aux;
         1:       bus <= 1'b0;
         default: bus <= 1'b1;
      endcase
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (aux) begin
         run <= run + 1;
      end else if (aux_prev) begin
         last_len <= run;
         run      <= 0;
         fall_cyc <= cyc;
         pulses   <= pulses + 1;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (timeout_err && !err_prev) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
      aux_prev <= aux;
      err_prev <= timeout_err;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_evt(input string tag, input int max_cycles);
      int d0 = done_cnt;
      int e0 = err_cnt;
      bit seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         step();
         seen = (done_cnt != d0) || (err_cnt != e0);
      end
      check({tag, "_event_seen"}, int'(seen), 1);
      if (seen) begin
         exp_t e;
         check({tag, "_sb_nonempty"}, int'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_is_err"}, int'(err_cnt != e0), int'(e.is_err));
            check({tag, "_cause"}, int'(cause), int'(e.cause));
            check({tag, "_pulse_len"}, last_len, e.pulse_len);
            check({tag, "_latency"}, (e.is_err ? err_cyc : done_cyc) - fall_cyc, e.lat);
         end
      end
   endtask

   initial begin
      int d_before, e_before, p_before;
      bit found;

      // Reset state
      repeat (3) step();
      check("reset_outputs", int'({aux, busy, done, timeout_err, cause}), 0);
      sync_resetn = 1'b1;
      step();

      // 1: software pulse with echoing generator
      d_before = done_cnt;
      sb.push_back('{cause: 3'b001, is_err: 1'b0, pulse_len: 16, lat: 2});
      sw = 1'b1;
      step();
      sw = 1'b0;
      check("t1_accept_aux_busy", int'({aux, busy}), 3);
      wait_evt("t1", 200);
      step();
      check("t1_done_one_cycle", int'({busy, done}), 0);
      check("t1_done_count", done_cnt - d_before, 1);

      // 2: simultaneous watchdog and debug
      p_before = pulses;
      sb.push_back('{cause: 3'b110, is_err: 1'b0, pulse_len: 16, lat: 2});
      wdt = 1'b1; dbg = 1'b1;
      step();
      wdt = 1'b0; dbg = 1'b0;
      wait_evt("t2", 200);
      check("t2_single_pulse", pulses - p_before, 1);
      step();

      // 3: generator never responds
      gen_mode = 1;
      step();
      d_before = done_cnt;
      sb.push_back('{cause: 3'b001, is_err: 1'b1, pulse_len: 16, lat: 0});
      sw = 1'b1;
      step();
      sw = 1'b0;
      wait_evt("t3", 200);
      check("t3_err_flag", int'(timeout_err), 1);
      repeat (5) step();
      check("t3_no_done", done_cnt - d_before, 0);
      check("t3_err_sticky", int'(timeout_err), 1);

      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t3_err_cleared", int'(timeout_err), 0);

      // 4: release never comes
      gen_mode = 2;
      step();
      sb.push_back('{cause: 3'b001, is_err: 1'b1, pulse_len: 16, lat: 1024});
      sw = 1'b1;
      step();
      sw = 1'b0;
      wait_evt("t4", 1200);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t4_err_cleared", int'(timeout_err), 0);
      gen_mode = 0;
      repeat (3) step();

      // 5: software pulse during WAIT_REL is ignored
      d_before = done_cnt;
      sb.push_back('{cause: 3'b100, is_err: 1'b0, pulse_len: 16, lat: 2});
      dbg = 1'b1;
      step();
      dbg = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         found = !aux;
      end
      check("t5_pulse_ended", int'(found), 1);
      sw = 1'b1;
      step();
      sw = 1'b0;
      wait_evt("t5", 50);
      repeat (20) step();
      check("t5_single_done", done_cnt - d_before, 1);
      check("t5_idle", int'({busy, aux}), 0);
      check("t5_cause_kept", int'(cause), 4);

      // 6: reset during ASSERT
      d_before = done_cnt;
      e_before = err_cnt;
      sw = 1'b1;
      step();
      sw = 1'b0;
      repeat (4) step();
      check("t6_mid_pulse", int'(aux), 1);
      sync_resetn = 1'b0;
      step();
      check("t6_reset_outputs", int'({aux, busy, done, timeout_err, cause}), 0);
      sync_resetn = 1'b1;
      repeat (40) step();
      check("t6_no_done", done_cnt - d_before, 0);
      check("t6_no_err", err_cnt - e_before, 0);
      check("t6_still_idle", int'(busy), 0);

      // 7: held watchdog level is accepted again after one IDLE cycle
      sb.push_back('{cause: 3'b010, is_err: 1'b0, pulse_len: 16, lat: 2});
      sb.push_back('{cause: 3'b010, is_err: 1'b0, pulse_len: 16, lat: 2});
      wdt = 1'b1;
      wait_evt("t7a", 200);
      step();
      check("t7_idle_gap", int'(busy), 0);
      wait_evt("t7b", 200);
      wdt = 1'b0;
      repeat (5) step();
      check("t7_back_idle", int'(busy), 0);
      check("t7_sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
